// File: rtl/spidergon_router_node_pkg.sv
// spidergon_router_node_pkg: direction codes and the shortest-path route function
// Exports ANTI_CLOCKWISE/CLOCKWISE/ACROSS/STOP (port index == direction code)
// and route_dir(dest, current, n), which returns the output port for a head flit.
package spidergon_router_node_pkg;

    localparam logic [1:0] ANTI_CLOCKWISE = 2'd0;
    localparam logic [1:0] CLOCKWISE      = 2'd1;
    localparam logic [1:0] ACROSS         = 2'd2;
    localparam logic [1:0] STOP           = 2'd3;

    // n is a power of two, so the modulo is a mask; rel < n keeps r4 exact in 32 bits
    function automatic logic [1:0] route_dir(
        input int unsigned dest,
        input int unsigned current,
        input int unsigned n
    );
        int unsigned rel;
        int unsigned r4;
        rel = (dest - current) & (n - 1);
        r4  = rel * 4;
        return (r4 == 0) ? STOP :
               (r4 <= n) ? CLOCKWISE :
               (r4 >= 3 * n) ? ANTI_CLOCKWISE : ACROSS;
    endfunction

endpackage

// File: rtl/spidergon_router_node_if.sv
// spidergon_router_node_if: bundled flit handshake for the four router ports
// in_flit/in_valid/in_ready : upstream side, slice p = port p
// out_flit/out_valid/out_ready : downstream side, slice p = port p
// master = network/testbench side, slave = router side
interface spidergon_router_node_if #(
    parameter int FLIT_WIDTH = 32
);
    logic [4*FLIT_WIDTH-1:0] in_flit;
    logic [3:0]              in_valid;
    logic [3:0]              in_ready;
    logic [4*FLIT_WIDTH-1:0] out_flit;
    logic [3:0]              out_valid;
    logic [3:0]              out_ready;

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid
    );
endinterface

// File: rtl/spidergon_router_node_fifo.sv
// spidergon_router_node_fifo: synchronous flit FIFO with registered occupancy
// clk, reset (sync active-low), i_push/i_data write, i_pop read,
// o_head = oldest entry, o_full/o_empty from the registered count only.
module spidergon_router_node_fifo #(
    parameter int FLIT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [FLIT_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [FLIT_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign o_empty = r_count == '0;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/spidergon_router_node.sv
// spidergon_router_node: 4-port Spidergon router with input FIFOs and per-output RR arbitration
// clk, reset (sync active-low), i_current_node (static node id),
// bus (slave modport): in_* accept flits per port, out_* present registered flits per port.
module spidergon_router_node
    import spidergon_router_node_pkg::*;
#(
`ifdef FORMAL
    parameter int NUM_OF_NODES = 8,
`else
    parameter int NUM_OF_NODES = 32,
`endif
    parameter int FLIT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    localparam int NODE_BITS   = $clog2(NUM_OF_NODES)
) (
    input logic                 clk,
    input logic                 reset,
    input logic [NODE_BITS-1:0] i_current_node,
    spidergon_router_node_if.slave bus
);
    logic [FLIT_WIDTH-1:0] w_head [4];
    logic [1:0]            w_dir  [4];
    logic [3:0]            w_gnt  [4];
    logic [3:0]            w_full;
    logic [3:0]            w_empty;
    logic [3:0]            w_push;
    logic [3:0]            w_pop;

    assign bus.in_ready = reset ? ~w_full : 4'b0;
    assign w_push       = bus.in_valid & bus.in_ready;

    // Each head routes to exactly one output, so at most one grant hits any input
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < 4; k++) w_pop = w_pop | w_gnt[k];
    end

    genvar i;
    for (i = 0; i < 4; i++) begin : g_in
        spidergon_router_node_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .i_push (w_push[i]),
            .i_data (bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH]),
            .i_pop  (w_pop[i]),
            .o_head (w_head[i]),
            .o_full (w_full[i]),
            .o_empty(w_empty[i])
        );
        assign w_dir[i] = route_dir(32'(w_head[i][NODE_BITS-1:0]), 32'(i_current_node), NUM_OF_NODES);
    end

    genvar o;
    for (o = 0; o < 4; o++) begin : g_out
        logic [3:0]            w_req;
        logic                  w_load;
        logic                  w_any;
        logic [1:0]            w_sel;
        logic                  r_valid;
        logic [FLIT_WIDTH-1:0] r_flit;
        logic [1:0]            r_rr;

        // Scan offsets high to low so the requester nearest r_rr wins
        always_comb begin
            for (int k = 0; k < 4; k++) w_req[k] = !w_empty[k] && w_dir[k] == 2'(o);
            w_load = !r_valid || bus.out_ready[o];
            w_any  = 1'b0;
            w_sel  = r_rr;
            for (int k = 3; k >= 0; k--) begin
                if (w_req[r_rr + 2'(k)]) begin
                    w_any = 1'b1;
                    w_sel = r_rr + 2'(k);
                end
            end
        end

        assign w_gnt[o] = (w_load && w_any) ? 4'b1 << w_sel : 4'b0;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_valid <= 1'b0;
                r_flit  <= '0;
                r_rr    <= '0;
            end else if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_flit <= w_head[w_sel];
                    r_rr   <= w_sel + 2'd1;
                end
            end
        end

        assign bus.out_valid[o]                          = r_valid;
        assign bus.out_flit[o*FLIT_WIDTH +: FLIT_WIDTH] = r_flit;
    end
endmodule
